// File: rtl/key_scan_if.sv
// Key/octave inputs and note/gate outputs between the keyboard scanner and its user.
interface key_scan_if;
    logic [11:0] keys_i;
    logic        octUp_i;
    logic        octDn_i;
    logic [7:0]  note_o;
    logic        enable_o;
    logic        noteChg_o;
    logic [2:0]  octave_o;

    modport master (
        output keys_i, octUp_i, octDn_i,
        input  note_o, enable_o, noteChg_o, octave_o
    );

    modport slave (
        input  keys_i, octUp_i, octDn_i,
        output note_o, enable_o, noteChg_o, octave_o
    );
endinterface

// File: rtl/key_scan.sv
// Debounced 12-key keyboard with octave buttons, producing a lowest-key-priority MIDI note and gate.
module key_scan #(
    parameter int DEB_DIV   = 10000,
    parameter int DEB_LEN   = 4,
    parameter int BASE_NOTE = 24,
    parameter int OCT_MAX   = 6,
    parameter int OCT_RESET = 3
) (
    input logic       clk_i,
    input logic       rst_i,
    key_scan_if.slave bus
);
    localparam int NIN   = 14;
    localparam int DIV_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DEB_DIV - 1);
    localparam logic [3:0]       RUN_LEN    = 4'(DEB_LEN);
    localparam logic [2:0]       OCT_TOP    = 3'(OCT_MAX);
    localparam logic [2:0]       OCT_INIT   = 3'(OCT_RESET);
    localparam logic [7:0]       NOTE_BASE  = 8'(BASE_NOTE);
    localparam logic [7:0]       NOTE_RESET = 8'(BASE_NOTE + 12 * OCT_RESET);

    if (BASE_NOTE + 12 * OCT_MAX + 11 > 127) begin : g_note_range_check
        $error("key_scan: BASE_NOTE + 12*OCT_MAX + 11 exceeds 127");
    end
    if (OCT_RESET > OCT_MAX || OCT_MAX > 7 || OCT_RESET < 0) begin : g_octave_check
        $error("key_scan: OCT_RESET must lie in 0..OCT_MAX and OCT_MAX <= 7");
    end
    if (DEB_LEN < 2 || DEB_LEN > 15) begin : g_deb_len_check
        $error("key_scan: DEB_LEN outside 2..15");
    end
    if (DEB_DIV < 2 || DEB_DIV > (1 << 20)) begin : g_deb_div_check
        $error("key_scan: DEB_DIV outside 2..2^20");
    end

    // Bit layout: [11:0] keys, [12] octave up, [13] octave down.
    logic [NIN-1:0]   raw_in;
    logic [NIN-1:0]   sync1_reg, sync2_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic             tick;
    logic [NIN-1:0]   deb_reg, deb_next;
    logic [3:0]       run_reg  [NIN];
    logic [3:0]       run_next [NIN];
    logic [1:0]       btn_prev_reg;
    logic [2:0]       octave_reg, octave_next;
    logic [7:0]       note_reg;
    logic             enable_reg, note_chg_reg;
    logic [3:0]       sel_idx;
    logic             any_key;
    logic             up_rise, dn_rise;
    logic [7:0]       note_calc;

    assign raw_in = {bus.octDn_i, bus.octUp_i, bus.keys_i};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_reg   <= '0;
            sync2_reg   <= '0;
            div_cnt_reg <= '0;
        end else begin
            sync1_reg   <= raw_in;
            sync2_reg   <= sync1_reg;
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_W'(1);
        end
    end

    assign tick = (div_cnt_reg == DIV_LAST);

    // A level flips only after RUN_LEN consecutive ticks that disagree with it.
    for (genvar gi = 0; gi < NIN; gi++) begin : g_deb
        logic       differ;
        logic [3:0] run_inc;
        logic       run_done;

        assign differ   = sync2_reg[gi] ^ deb_reg[gi];
        assign run_inc  = run_reg[gi] + 4'd1;
        assign run_done = (run_inc == RUN_LEN);

        assign run_next[gi] = !tick   ? run_reg[gi] :
                              !differ ? 4'd0 :
                              run_done ? 4'd0 : run_inc;
        assign deb_next[gi] = (tick && differ && run_done) ? ~deb_reg[gi] : deb_reg[gi];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_reg <= '0;
            for (int i = 0; i < NIN; i++) run_reg[i] <= 4'd0;
        end else begin
            deb_reg <= deb_next;
            for (int i = 0; i < NIN; i++) run_reg[i] <= run_next[i];
        end
    end

    // Descending scan so the lowest pressed key is the last, winning assignment.
    always_comb begin
        sel_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (deb_reg[i]) sel_idx = 4'(i);
        end
    end

    assign any_key = |deb_reg[11:0];
    assign up_rise = deb_reg[12] & ~btn_prev_reg[0];
    assign dn_rise = deb_reg[13] & ~btn_prev_reg[1];

    always_comb begin
        octave_next = octave_reg;
        if (up_rise && !dn_rise && octave_reg != OCT_TOP) begin
            octave_next = octave_reg + 3'd1;
        end else if (dn_rise && !up_rise && octave_reg != 3'd0) begin
            octave_next = octave_reg - 3'd1;
        end
    end

    // Uses the next octave so an octave step and its note change land in the same cycle.
    assign note_calc = NOTE_BASE + 8'(octave_next) * 8'd12 + {4'b0000, sel_idx};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_prev_reg <= 2'b00;
            octave_reg   <= OCT_INIT;
            note_reg     <= NOTE_RESET;
            enable_reg   <= 1'b0;
            note_chg_reg <= 1'b0;
        end else begin
            btn_prev_reg <= deb_reg[13:12];
            octave_reg   <= octave_next;
            enable_reg   <= any_key;
            note_chg_reg <= any_key && (!enable_reg || note_calc != note_reg);
            if (any_key) note_reg <= note_calc;
        end
    end

    assign bus.note_o    = note_reg;
    assign bus.enable_o  = enable_reg;
    assign bus.noteChg_o = note_chg_reg;
    assign bus.octave_o  = octave_reg;
endmodule

// File: tb/tb_key_scan.sv
// Scoreboard bench for key_scan: expected output events are queued as stimulus is applied.
module tb_key_scan;
    typedef struct packed {
        logic [7:0] note;
        logic       en;
        logic       chg;
        logic [2:0] oct;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    key_scan_if bus ();

    key_scan #(
        .DEB_DIV  (4),
        .DEB_LEN  (3),
        .BASE_NOTE(24),
        .OCT_MAX  (6),
        .OCT_RESET(3)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    evt_t exp_q[$];
    bit   mon_en      = 1'b0;
    int   last_evt_cyc = 0;
    int   drive_cyc   = 0;
    logic [7:0] prev_note;
    logic       prev_en;
    logic [2:0] prev_oct;
    evt_t mon_got, mon_exp;

    function automatic evt_t mk(int note, bit en, bit chg, int oct);
        evt_t e;
        e.note = 8'(note);
        e.en   = en;
        e.chg  = chg;
        e.oct  = 3'(oct);
        return e;
    endfunction

    // Any pulse or change of note/gate/octave is an event that must match the queue head.
    always @(negedge clk) begin
        if (mon_en && (bus.noteChg_o !== 1'b0 || bus.note_o !== prev_note ||
                       bus.enable_o !== prev_en || bus.octave_o !== prev_oct)) begin
            mon_got = {bus.note_o, bus.enable_o, bus.noteChg_o, bus.octave_o};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_event cyc=%0d got note=%0d en=%0b chg=%0b oct=%0d, required no event",
                         cyc, mon_got.note, mon_got.en, mon_got.chg, mon_got.oct);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    miscompares++;
                    $display("FAIL event cyc=%0d got note=%0d en=%0b chg=%0b oct=%0d, required note=%0d en=%0b chg=%0b oct=%0d",
                             cyc, mon_got.note, mon_got.en, mon_got.chg, mon_got.oct,
                             mon_exp.note, mon_exp.en, mon_exp.chg, mon_exp.oct);
                end else begin
                    $display("event cyc=%0d note=%0d en=%0b chg=%0b oct=%0d ok",
                             cyc, mon_got.note, mon_got.en, mon_got.chg, mon_got.oct);
                end
            end
            last_evt_cyc = cyc;
        end
        prev_note = bus.note_o;
        prev_en   = bus.enable_o;
        prev_oct  = bus.octave_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_inputs(input logic [11:0] k, input logic up, input logic dn);
        @(negedge clk);
        bus.keys_i  = k;
        bus.octUp_i = up;
        bus.octDn_i = dn;
        drive_cyc   = cyc;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(output int left);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        left = exp_q.size();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.keys_i  = 12'h000;
        bus.octUp_i = 1'b0;
        bus.octDn_i = 1'b0;
        rst = 1'b1;
        settle(3);
        rst = 1'b0;
        vectors++;
        if (bus.note_o !== 8'd60) begin
            miscompares++;
            $display("FAIL reset_note got %0d required 60", bus.note_o);
        end
        vectors++;
        if (bus.octave_o !== 3'd3) begin
            miscompares++;
            $display("FAIL reset_octave got %0d required 3", bus.octave_o);
        end
        vectors++;
        if (bus.enable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_enable got %0b required 0", bus.enable_o);
        end
        vectors++;
        if (bus.noteChg_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_notechg got %0b required 0", bus.noteChg_o);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_press();
        int left, c0, lat;
        exp_q.push_back(mk(64, 1, 1, 3));
        set_inputs(12'h010, 1'b0, 1'b0);
        c0 = drive_cyc;
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL press_drain pending=%0d required 0", left);
        end
        // Two sync flops, first usable tick within 4 edges, then two more ticks and one output register.
        lat = last_evt_cyc - c0;
        vectors++;
        if (lat < 12 || lat > 15) begin
            miscompares++;
            $display("FAIL press_latency got %0d cycles required 12..15", lat);
        end
        settle(20);
        exp_q.push_back(mk(64, 0, 0, 3));
        set_inputs(12'h000, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL release_drain pending=%0d required 0", left);
        end
        settle(20);
    endtask

    task automatic test_glitch();
        set_inputs(12'h010, 1'b0, 1'b0);
        repeat (7) @(negedge clk);
        set_inputs(12'h000, 1'b0, 1'b0);
        settle(40);
        vectors++;
        if (bus.enable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_enable got %0b required 0", bus.enable_o);
        end
    endtask

    task automatic test_priority();
        int left;
        exp_q.push_back(mk(64, 1, 1, 3));
        set_inputs(12'h010, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL prio_low_drain pending=%0d required 0", left);
        end
        set_inputs(12'h210, 1'b0, 1'b0);
        settle(30);
        vectors++;
        if (bus.note_o !== 8'd64) begin
            miscompares++;
            $display("FAIL prio_hold_note got %0d required 64", bus.note_o);
        end
        exp_q.push_back(mk(69, 1, 1, 3));
        set_inputs(12'h200, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL prio_next_drain pending=%0d required 0", left);
        end
        exp_q.push_back(mk(69, 0, 0, 3));
        set_inputs(12'h000, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL prio_release_drain pending=%0d required 0", left);
        end
        settle(20);
    endtask

    task automatic test_octave();
        int left;
        exp_q.push_back(mk(60, 1, 1, 3));
        set_inputs(12'h001, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL oct_key0_drain pending=%0d required 0", left);
        end
        for (int step = 0; step < 4; step++) begin
            if (step < 3) exp_q.push_back(mk(60 + 12 * (step + 1), 1, 1, 4 + step));
            set_inputs(12'h001, 1'b1, 1'b0);
            if (step < 3) begin
                wait_drain(left);
                vectors++;
                if (left != 0) begin
                    miscompares++;
                    $display("FAIL oct_up%0d_drain pending=%0d required 0", step, left);
                end
            end
            settle(30);
            set_inputs(12'h001, 1'b0, 1'b0);
            settle(30);
        end
        vectors++;
        if (bus.octave_o !== 3'd6 || bus.note_o !== 8'd96) begin
            miscompares++;
            $display("FAIL oct_saturate got oct=%0d note=%0d required oct=6 note=96", bus.octave_o, bus.note_o);
        end
        set_inputs(12'h001, 1'b1, 1'b1);
        settle(30);
        set_inputs(12'h001, 1'b0, 1'b0);
        settle(30);
        vectors++;
        if (bus.octave_o !== 3'd6) begin
            miscompares++;
            $display("FAIL oct_both_at_top got %0d required 6", bus.octave_o);
        end
        exp_q.push_back(mk(84, 1, 1, 5));
        set_inputs(12'h001, 1'b0, 1'b1);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL oct_dn_drain pending=%0d required 0", left);
        end
        settle(30);
        set_inputs(12'h001, 1'b0, 1'b0);
        settle(30);
        set_inputs(12'h001, 1'b1, 1'b1);
        settle(30);
        set_inputs(12'h001, 1'b0, 1'b0);
        settle(30);
        vectors++;
        if (bus.octave_o !== 3'd5 || bus.note_o !== 8'd84) begin
            miscompares++;
            $display("FAIL oct_both_mid got oct=%0d note=%0d required oct=5 note=84", bus.octave_o, bus.note_o);
        end
        exp_q.push_back(mk(84, 0, 0, 5));
        set_inputs(12'h000, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL oct_release_drain pending=%0d required 0", left);
        end
        settle(20);
        // Octave moves with no key held; the note must stay put.
        exp_q.push_back(mk(84, 0, 0, 4));
        set_inputs(12'h000, 1'b0, 1'b1);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL oct_idle_dn_drain pending=%0d required 0", left);
        end
        settle(30);
        set_inputs(12'h000, 1'b0, 1'b0);
        settle(30);
    endtask

    task automatic test_reset_mid_hold();
        int left, rc;
        exp_q.push_back(mk(79, 1, 1, 4));
        set_inputs(12'h080, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL hold7_drain pending=%0d required 0", left);
        end
        settle(10);
        exp_q.push_back(mk(60, 0, 0, 3));
        exp_q.push_back(mk(67, 1, 1, 3));
        @(negedge clk);
        rst = 1'b1;
        rc  = cyc + 1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (bus.enable_o !== 1'b0 || bus.note_o !== 8'd60) begin
            miscompares++;
            $display("FAIL midreset_out got en=%0b note=%0d required en=0 note=60", bus.enable_o, bus.note_o);
        end
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL midreset_drain pending=%0d required 0", left);
        end
        // Ticks at 4, 8 and 12 cycles after the reset edge, gate one cycle later.
        vectors++;
        if (last_evt_cyc - rc != 13) begin
            miscompares++;
            $display("FAIL midreset_latency got %0d cycles required 13", last_evt_cyc - rc);
        end
        exp_q.push_back(mk(67, 0, 0, 3));
        set_inputs(12'h000, 1'b0, 1'b0);
        wait_drain(left);
        vectors++;
        if (left != 0) begin
            miscompares++;
            $display("FAIL midreset_release_drain pending=%0d required 0", left);
        end
        settle(20);
    endtask

    initial begin
        test_reset();
        test_press();
        test_glitch();
        test_priority();
        test_octave();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter DEB_DIV, default 10000: clk_i cycles per debounce sample tick (legal range 2..2^20).
REQ-002 Parameter DEB_LEN, default 4: consecutive equal samples required to accept a new key level (legal range 2..15).
REQ-003 Parameter BASE_NOTE, default 24: MIDI note of key 0 at octave 0.
REQ-004 Parameter OCT_MAX, default 6: highest octave value; BASE_NOTE+12*OCT_MAX+11 SHALL be <=127, else elaboration error.
REQ-005 Parameter OCT_RESET, default 3: octave value after reset; SHALL be <=OCT_MAX.
REQ-006 Clock and reset SHALL be exactly as decided: one clock, clk_i; reset rst_i, synchronous, active-high.
REQ-007 clk_i  input  1  system clock; all state on rising edge.
REQ-008 rst_i  input  1  synchronous active-high reset.
REQ-009 keys_i  input  12  raw asynchronous key levels, bit n = semitone n, 1 = pressed.
REQ-010 octUp_i  input  1  raw asynchronous octave-up button, 1 = pressed.
REQ-011 octDn_i  input  1  raw asynchronous octave-down button, 1 = pressed.
REQ-012 note_o  output  8  MIDI note for the downstream oscillator, bit 7 always 0.
REQ-013 enable_o  output  1  gate to the oscillator, 1 while any debounced key is pressed.
REQ-014 noteChg_o  output  1  one-cycle pulse when note_o changes or enable_o rises.
REQ-015 octave_o  output  3  current octave value.

Function
REQ-016 Each of the 14 raw inputs SHALL pass a 2-flop synchroniser before any other use.
REQ-017 A free-running divider SHALL assert a one-cycle tick every DEB_DIV cycles; the first tick comes DEB_DIV cycles after reset release.
REQ-018 On each tick each synchronised input SHALL be sampled. If the sample differs from the debounced level, a per-input run counter increments; otherwise it clears. When the count reaches DEB_LEN, the debounced level SHALL toggle and the counter SHALL clear.
REQ-019 Between ticks, debounced levels and run counters SHALL hold.
REQ-020 Key selection SHALL be lowest-index priority: the selected index is the lowest set bit of the debounced key vector.
REQ-021 note_o SHALL equal BASE_NOTE + 12*octave + selected index, computed at 8-bit width with no overflow given REQ-004.
REQ-022 enable_o SHALL be 1 iff the debounced key vector is nonzero.
REQ-023 When all keys are released, note_o SHALL hold its last value and enable_o SHALL drop.
REQ-024 Octave button: on a debounced rising edge, octUp SHALL increment and octDn SHALL decrement the octave. The octave saturates at OCT_MAX and 0; a saturated press has no effect.
REQ-025 If both octave buttons have a debounced rising edge in the same cycle, the octave SHALL not change.
REQ-026 Holding an octave button SHALL produce exactly one step; auto-repeat is not allowed.
REQ-027 note_o, enable_o and octave_o SHALL be registered and SHALL update exactly one clk_i cycle after the debounced-state change that causes them.
REQ-028 An octave change while a key is held SHALL update note_o per REQ-027 and pulse noteChg_o; while no key is held, note_o SHALL not change.
REQ-029 noteChg_o SHALL assert in the same cycle that the new note_o/enable_o values first appear, for exactly one cycle. A key release alone (enable_o falling) SHALL not pulse it.
REQ-030 Pressing a higher key while a lower key is held SHALL not change note_o. Releasing the lower key SHALL move note_o to the next-lowest held key with a noteChg_o pulse.

Reset
REQ-031 While rst_i=1 at a clock edge, the following SHALL load:
  - synchronisers, debounced levels, run counters and divider: 0
  - octave: OCT_RESET
  - note_o: BASE_NOTE+12*OCT_RESET
  - enable_o: 0
  - noteChg_o: 0
REQ-032 Reset asserted mid-debounce or mid-hold SHALL discard all progress. A key still held after release of rst_i SHALL require a full DEB_LEN-sample debounce before enable_o rises.

Verification (bench parameters DEB_DIV=4, DEB_LEN=3, defaults otherwise)
REQ-033 Reset with all inputs 0 -> note_o=60, octave_o=3, enable_o=0, noteChg_o=0.
REQ-034 keys_i=12'h010 held steady -> enable_o=1 and note_o=64 one cycle after the third consecutive differing sample, with a single noteChg_o pulse. Releasing it -> enable_o=0, note_o stays 64, no pulse.
REQ-035 keys_i bit 4 glitching high for 2 ticks then low -> enable_o stays 0 and no pulse.
REQ-036 Hold key 4, then press key 9 -> note_o stays 64. Release key 4 -> note_o=69 with one pulse.
REQ-037 Hold key 0, press octUp 4 times (each press debounced and released) -> octave_o steps 4,5,6,6 and note_o 72,84,96,96. Press octUp and octDn together -> no change.
REQ-038 Assert rst_i for one cycle while key 7 is held and debounced -> next cycle enable_o=0 and note_o=60. enable_o rises again only after 3 new samples.
